// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection scheduler: state encodings,
// default phase durations and the lamp decode helper.
package traffic_pkg;

  // Encodings are visible on the debug phase port, so they are fixed.
  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALLRED_A  = 3'd2,
    PED_WALK  = 3'd3,
    EW_GREEN  = 3'd4,
    EW_YELLOW = 3'd5,
    ALLRED_B  = 3'd6
  } state_t;

  // Default durations in clock cycles.
  localparam int GREEN_T_DEF  = 8;
  localparam int YELLOW_T_DEF = 2;
  localparam int ALLRED_T_DEF = 1;
  localparam int WALK_T_DEF   = 4;
  localparam int CNT_W_DEF    = 8;

  typedef struct packed {
    logic ns_red;
    logic ns_yellow;
    logic ns_green;
    logic ew_red;
    logic ew_yellow;
    logic ew_green;
    logic walk;
  } lamps_t;

  // One lamp per direction; red is the default for every state that does
  // not explicitly grant that direction.
  function automatic lamps_t decode_lamps(input state_t s);
    lamps_t l;
    l.ns_green  = (s == NS_GREEN);
    l.ns_yellow = (s == NS_YELLOW);
    l.ns_red    = !(l.ns_green || l.ns_yellow);
    l.ew_green  = (s == EW_GREEN);
    l.ew_yellow = (s == EW_YELLOW);
    l.ew_red    = !(l.ew_green || l.ew_yellow);
    l.walk      = (s == PED_WALK);
    return l;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Countdown timer for the current phase: load on state entry, count down
// to zero and hold there until the next load.
module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  // Load has priority; the owner asserts load during reset so the timer
  // needs no reset of its own.
  always_ff @(posedge clk) begin
    // NOTE: registers are always updated with non-blocking assignments so
    // every flop samples pre-edge values regardless of statement order.
    if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/intersection_scheduler.sv
// Two-road intersection sequencer with pedestrian walk phase. The main road
// rests on green until a side-road car or a pedestrian asks for service.
module intersection_scheduler
  import traffic_pkg::*;
#(
  parameter int GREEN_T  = GREEN_T_DEF,
  parameter int YELLOW_T = YELLOW_T_DEF,
  parameter int ALLRED_T = ALLRED_T_DEF,
  parameter int WALK_T   = WALK_T_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ew_sensor,
  input  logic       ped_req,
  output logic       ns_red,
  output logic       ns_yellow,
  output logic       ns_green,
  output logic       ew_red,
  output logic       ew_yellow,
  output logic       ew_green,
  output logic       walk,
  output logic [2:0] phase
);

  state_t           state;
  state_t           next_state;
  lamps_t           lamps;
  logic             ew_pending;
  logic             ped_pending;
  logic             timer_zero;
  logic             timer_load;
  logic [CNT_W-1:0] timer_val;

  // Timer reload value is the duration of the state being entered, minus
  // one, so that each state lasts exactly its duration.
  function automatic logic [CNT_W-1:0] phase_len(input state_t s);
    case (s)
      NS_GREEN, EW_GREEN:    phase_len = CNT_W'(GREEN_T - 1);
      NS_YELLOW, EW_YELLOW:  phase_len = CNT_W'(YELLOW_T - 1);
      ALLRED_A, ALLRED_B:    phase_len = CNT_W'(ALLRED_T - 1);
      PED_WALK:              phase_len = CNT_W'(WALK_T - 1);
      default:               phase_len = CNT_W'(GREEN_T - 1);
    endcase
  endfunction

  // Next-state selection: a state is only left in the cycle its timer is 0.
  always_comb begin
    // NOTE: default first so every path assigns next_state and no latch forms.
    next_state = state;
    if (timer_zero) begin
      case (state)
        NS_GREEN:  if (ew_pending || ped_pending) next_state = NS_YELLOW;
        NS_YELLOW: next_state = ALLRED_A;
        ALLRED_A:  next_state = ped_pending ? PED_WALK : EW_GREEN;
        PED_WALK:  next_state = ew_pending ? EW_GREEN : ALLRED_B;
        EW_GREEN:  next_state = EW_YELLOW;
        EW_YELLOW: next_state = ALLRED_B;
        ALLRED_B:  next_state = NS_GREEN;
        default:   next_state = NS_GREEN;
      endcase
    end
  end

  // Every transition changes state, so "state differs" marks a state entry.
  // Resting on NS green does not reload, leaving the timer parked at 0.
  assign timer_load = reset || (next_state != state);
  assign timer_val  = reset ? phase_len(NS_GREEN) : phase_len(next_state);

  phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .load     (timer_load),
    .load_val (timer_val),
    .zero     (timer_zero)
  );

  // State, request latches and registered lamp outputs.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and checked first so it overrides any
    // transition or request in the same cycle, including mid-phase.
    if (reset) begin
      state       <= NS_GREEN;
      ew_pending  <= 1'b0;
      ped_pending <= 1'b0;
      lamps       <= decode_lamps(NS_GREEN);
    end else begin
      state <= next_state;
      lamps <= decode_lamps(next_state);
      // Clearing on entry wins over a sensor sample in that same cycle.
      if (next_state == EW_GREEN && state != EW_GREEN) begin
        ew_pending <= 1'b0;
      end else if (ew_sensor) begin
        ew_pending <= 1'b1;
      end
      // Button presses during the walk itself are ignored.
      if (next_state == PED_WALK && state != PED_WALK) begin
        ped_pending <= 1'b0;
      end else if (ped_req && state != PED_WALK) begin
        ped_pending <= 1'b1;
      end
    end
  end

  assign ns_red    = lamps.ns_red;
  assign ns_yellow = lamps.ns_yellow;
  assign ns_green  = lamps.ns_green;
  assign ew_red    = lamps.ew_red;
  assign ew_yellow = lamps.ew_yellow;
  assign ew_green  = lamps.ew_green;
  assign walk      = lamps.walk;
  assign phase     = state;

endmodule

// File: tb/tb_intersection_scheduler.sv
// Scoreboard bench for intersection_scheduler: directed scenarios push the
// expected phase per cycle, a negedge monitor pops and compares, and checks
// lamp invariants and request service latency throughout.
module tb_intersection_scheduler;

  localparam int P_NSG = 0, P_NSY = 1, P_ARA = 2, P_WALK = 3;
  localparam int P_EWG = 4, P_EWY = 5, P_ARB = 6;
  localparam int MAX_LAT = 2*8 + 2*2 + 2*1 + 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ew_sensor = 1'b0;
  logic       ped_req = 1'b0;
  logic       ns_red, ns_yellow, ns_green;
  logic       ew_red, ew_yellow, ew_green;
  logic       walk;
  logic [2:0] phase;

  typedef struct {
    int scen;
    int cyc;
    int ph;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  bit   started = 1'b0;
  bit   rand_mode = 1'b0;

  intersection_scheduler dut (
    .clk       (clk),
    .reset     (reset),
    .ew_sensor (ew_sensor),
    .ped_req   (ped_req),
    .ns_red    (ns_red),
    .ns_yellow (ns_yellow),
    .ns_green  (ns_green),
    .ew_red    (ew_red),
    .ew_yellow (ew_yellow),
    .ew_green  (ew_green),
    .walk      (walk),
    .phase     (phase)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input bit ok, input int act, input int exp);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Lamp pattern {ns_r,ns_y,ns_g,ew_r,ew_y,ew_g,walk} for each phase.
  function automatic int lamps_of(input int ph);
    case (ph)
      P_NSG:        return 7'b0011000;
      P_NSY:        return 7'b0101000;
      P_ARA, P_ARB: return 7'b1001000;
      P_WALK:       return 7'b1001001;
      P_EWG:        return 7'b1000010;
      P_EWY:        return 7'b1000100;
      default:      return 0;
    endcase
  endfunction

  // Hand-derived phase timelines, cycle 0 = first cycle after reset.
  function automatic int exp_phase(input int scen, input int c);
    if (scen == 2 || (scen == 5 && c < 15)) begin
      if (c < 8)  return P_NSG;
      if (c < 10) return P_NSY;
      if (c < 11) return P_ARA;
      if (c < 19) return P_EWG;
      if (c < 21) return P_EWY;
      if (c < 22) return P_ARB;
      return P_NSG;
    end
    if (scen == 3) begin
      if (c < 8)  return P_NSG;
      if (c < 10) return P_NSY;
      if (c < 11) return P_ARA;
      if (c < 15) return P_WALK;
      if (c < 16) return P_ARB;
      return P_NSG;
    end
    if (scen == 4) begin
      if (c < 8)  return P_NSG;
      if (c < 10) return P_NSY;
      if (c < 11) return P_ARA;
      if (c < 15) return P_WALK;
      if (c < 23) return P_EWG;
      if (c < 25) return P_EWY;
      if (c < 26) return P_ARB;
      return P_NSG;
    end
    return P_NSG;
  endfunction

  // Called just after a rising edge; that edge samples reset.
  task automatic do_reset();
    reset = 1'b1;
    ew_sensor = 1'b0;
    ped_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic run_dir(input int scen, input int ncyc);
    exp_t e;
    do_reset();
    for (int c = 0; c < ncyc; c++) begin
      ew_sensor = (scen == 2 && c == 2) || (scen == 4 && c == 1) || (scen == 5 && c == 2);
      ped_req   = (scen == 3 && c == 3) || (scen == 4 && c == 1) || (scen == 5 && c == 13);
      reset     = (scen == 5 && c == 14);
      e.scen = scen;
      e.cyc  = c;
      e.ph   = exp_phase(scen, c);
      exp_q.push_back(e);
      @(posedge clk); #1;
    end
    ew_sensor = 1'b0;
    ped_req = 1'b0;
    reset = 1'b0;
  endtask

  // Monitor: scoreboard compare, invariants and service latency.
  int  cyc_n = 0;
  bit  prev_ew_green = 1'b0, prev_walk = 1'b0;
  bit  ew_out = 1'b0, ped_out = 1'b0;
  int  ew_t = 0, ped_t = 0;

  always @(negedge clk) begin
    exp_t e;
    bit   inv_ok;
    int   act_l;
    cyc_n++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      act_l = {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk};
      check($sformatf("s%0d_c%0d_phase", e.scen, e.cyc), phase === 3'(e.ph), int'(phase), e.ph);
      check($sformatf("s%0d_c%0d_lamps", e.scen, e.cyc), act_l == lamps_of(e.ph), act_l, lamps_of(e.ph));
    end
    if (started) begin
      inv_ok = (int'(ns_red) + int'(ns_yellow) + int'(ns_green) == 1) &&
               (int'(ew_red) + int'(ew_yellow) + int'(ew_green) == 1) &&
               (ns_red || ew_red) && (!walk || (ns_red && ew_red));
      check($sformatf("invariant_c%0d", cyc_n), inv_ok,
            {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk}, 1);
    end
    if (rand_mode) begin
      if (ew_out && ew_green && !prev_ew_green) begin
        check("ew_latency", cyc_n - ew_t <= MAX_LAT, cyc_n - ew_t, MAX_LAT);
        ew_out = 1'b0;
      end else if (ew_out && cyc_n - ew_t > MAX_LAT) begin
        check("ew_timeout", 1'b0, cyc_n - ew_t, MAX_LAT);
        ew_out = 1'b0;
      end
      if (ped_out && walk && !prev_walk) begin
        check("ped_latency", cyc_n - ped_t <= MAX_LAT, cyc_n - ped_t, MAX_LAT);
        ped_out = 1'b0;
      end else if (ped_out && cyc_n - ped_t > MAX_LAT) begin
        check("ped_timeout", 1'b0, cyc_n - ped_t, MAX_LAT);
        ped_out = 1'b0;
      end
      if (!ew_out && ew_sensor) begin
        ew_out = 1'b1;
        ew_t = cyc_n;
      end
      if (!ped_out && ped_req && !walk) begin
        ped_out = 1'b1;
        ped_t = cyc_n;
      end
    end else begin
      ew_out = 1'b0;
      ped_out = 1'b0;
    end
    prev_ew_green = ew_green;
    prev_walk = walk;
  end

  initial begin
    @(posedge clk); #1;
    do_reset();
    started = 1'b1;
    run_dir(1, 50);
    run_dir(2, 30);
    run_dir(3, 25);
    run_dir(4, 35);
    run_dir(5, 35);
    do_reset();
    rand_mode = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      ew_sensor = ($urandom_range(0, 7) == 0);
      ped_req   = ($urandom_range(0, 9) == 0);
      @(posedge clk); #1;
    end
    rand_mode = 1'b0;
    ew_sensor = 1'b0;
    ped_req = 1'b0;
    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) check("scoreboard_drain", 1'b0, exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
